// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO, one pop per frame.
// Frame: start, 8 data bits LSB first, optional even parity, stop.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rn,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_LAST = 16'(CLKS_PER_BIT - 2);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        parity_bit;
    logic        bit_end;

    assign bit_end = (baud_cnt == LAST);
    assign fifo_rn = (state == IDLE) & enable & ~fifo_empty & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (fifo_rn) begin
                    shreg      <= fifo_data;
                    parity_bit <= ^fifo_data;
                    state      <= START;
                    busy       <= 1'b1;
                    tx         <= 1'b0;
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                end
            end else begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
                // Registered pulse: raised one cycle early so it lands in the last stop cycle
                if (state == STOP && baud_cnt == PRE_LAST)
                    frame_done <= 1'b1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            tx    <= shreg[0];
                        end
                        DATA: begin
                            if (bit_idx == 3'd7) begin
                                if (PARITY_EN) begin
                                    state <= PARITY;
                                    tx    <= parity_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx      <= shreg[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                        STOP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity, one with parity,
// both at 4 clocks per bit.
module tb_fifo_uart_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable0, enable1;
    logic [7:0] data0, data1;
    logic       empty0, empty1;
    logic       rn0, rn1, tx0, tx1, busy0, busy1, fd0, fd1;

    int errors = 0;
    int checks = 0;
    int n1, n2;

    always #5 clock = ~clock;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable0),
        .fifo_data(data0), .fifo_empty(empty0), .fifo_rn(rn0),
        .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable1),
        .fifo_data(data1), .fifo_empty(empty1), .fifo_rn(rn1),
        .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one byte at a negedge, then check every cycle of the frame.
    // exp[i] is the line level of bit slot i (slot 0 = start bit).
    task automatic send_frame(input bit sel, input logic [7:0] data, input int unsigned nbits,
                              input logic [10:0] exp);
        if (sel) begin empty1 = 1'b0; data1 = data; end
        else     begin empty0 = 1'b0; data0 = data; end
        #1;
        check("pop_req", sel ? rn1 : rn0, 1);
        @(negedge clock);
        if (sel) empty1 = 1'b1; else empty0 = 1'b1;
        #1;
        for (int unsigned k = 1; k <= nbits * 4; k++) begin
            check("frame_tx", sel ? tx1 : tx0, exp[(k - 1) / 4]);
            check("frame_done", sel ? fd1 : fd0, (k == nbits * 4) ? 1 : 0);
            check("frame_busy", sel ? busy1 : busy0, 1);
            check("frame_no_pop", sel ? rn1 : rn0, 0);
            @(negedge clock);
        end
        check("end_busy", sel ? busy1 : busy0, 0);
        check("end_tx", sel ? tx1 : tx0, 1);
        check("end_done", sel ? fd1 : fd0, 0);
    endtask

    initial begin
        reset = 1'b1; enable0 = 1'b1; enable1 = 1'b1;
        data0 = 8'h00; data1 = 8'h00; empty0 = 1'b0; empty1 = 1'b1;

        // Reset state; fifo_rn must be gated by reset even with data pending
        @(negedge clock); #1;
        check("rst_tx", tx0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done", fd0, 0);
        check("rst_rn", rn0, 0);
        empty0 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1
        send_frame(1'b0, 8'hA5, 10, 11'b01101001010);

        // 0x07 with parity: 0,1,1,1,0,0,0,0,0,1,1
        send_frame(1'b1, 8'h07, 11, 11'b11000001110);

        // Empty FIFO for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("empty_rn", rn0, 0);
            check("empty_tx", tx0, 1);
            check("empty_busy", busy0, 0);
        end

        // Back-to-back 0x01 then 0x02
        n1 = -1; n2 = -1;
        empty0 = 1'b0; data0 = 8'h01;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (rn0 && n1 < 0) n1 = c;
            else if (rn0 && n2 < 0) n2 = c;
            if (n1 >= 0 && c == n1 + 6) check("b2b_f1_bit0", tx0, 1);
            if (n1 >= 0 && c == n1 + 41) begin
                check("b2b_gap_tx", tx0, 1);
                check("b2b_gap_busy", busy0, 0);
            end
            if (n2 >= 0 && c == n2 + 6)  check("b2b_f2_bit0", tx0, 0);
            if (n2 >= 0 && c == n2 + 10) check("b2b_f2_bit1", tx0, 1);
            @(negedge clock);
            if (n1 >= 0 && c == n1) data0 = 8'h02;
            if (n2 >= 0 && c == n2) empty0 = 1'b1;
            #1;
        end
        check("b2b_first", n1, 0);
        check("b2b_spacing", n2 - n1, 41);

        // Enable dropped during START with a second byte waiting
        @(negedge clock);
        empty0 = 1'b0; data0 = 8'h55;
        #1;
        check("en_pop", rn0, 1);
        @(negedge clock);
        enable0 = 1'b0; data0 = 8'h66;
        #1;
        check("en_start_busy", busy0, 1);
        check("en_start_tx", tx0, 0);
        for (int k = 2; k <= 40; k++) begin
            @(negedge clock);
            if (k == 6)  check("en_bit0", tx0, 1);
            if (k == 10) check("en_bit1", tx0, 0);
            if (k == 40) check("en_done", fd0, 1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("en_hold_rn", rn0, 0);
            check("en_hold_busy", busy0, 0);
            check("en_hold_tx", tx0, 1);
        end
        enable0 = 1'b1;
        #1;
        check("en_resume_rn", rn0, 1);
        @(negedge clock);
        empty0 = 1'b1;
        check("en_resume_busy", busy0, 1);
        check("en_resume_tx", tx0, 0);
        repeat (45) @(negedge clock);
        check("en_resume_idle", busy0, 0);

        // Reset during data bit 3 of 0xA5 (slot 4, cycles 17..20)
        empty0 = 1'b0; data0 = 8'hA5;
        #1;
        check("rstm_pop", rn0, 1);
        @(negedge clock);
        empty0 = 1'b1;
        repeat (17) @(negedge clock);
        check("rstm_pre_tx", tx0, 0);
        check("rstm_pre_busy", busy0, 1);
        reset = 1'b1;
        #1;
        check("rstm_tx", tx0, 1);
        check("rstm_busy", busy0, 0);
        check("rstm_done", fd0, 0);
        empty0 = 1'b0;
        #1;
        check("rstm_rn", rn0, 0);
        empty0 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("rstm_after_tx", tx0, 1);
            check("rstm_after_busy", busy0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit between data and stop.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 permits starting a new frame; 0 blocks new pops only.
REQ-006 fifo_data  input  8  upstream FIFO head word; valid whenever fifo_empty=0.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_rn  output  1  pop strobe to upstream FIFO; one cycle per consumed byte.
REQ-009 tx  output  1  serial line; idle/stop level 1.
REQ-010 busy  output  1  1 whenever FSM is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse in final cycle of stop bit.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; all state registered.
REQ-013 fifo_rn = (state==IDLE) & enable & !fifo_empty & !reset; purely combinational, no other term.
REQ-014 On the edge where fifo_rn=1: fifo_data captured into 8-bit shift register, parity computed and registered, state -> START, baud counter and bit index cleared.
REQ-015 A byte is popped only in IDLE; fifo_rn never asserts in START/DATA/PARITY/STOP, so exactly one pop per frame.
REQ-016 Baud counter counts 0..CLKS_PER_BIT-1 in each non-IDLE state; state/bit advance on the cycle the counter equals CLKS_PER_BIT-1, then counter wraps to 0.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-018 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index 0..7; after bit 7 -> PARITY if PARITY_EN=1 else STOP.
REQ-019 PARITY: tx = XOR of the 8 captured bits (even parity overall) for CLKS_PER_BIT cycles, then -> STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the last of those cycles; then -> IDLE.
REQ-021 tx is a registered output; tx=1 in IDLE; no glitches at bit boundaries.
REQ-022 Latency: first start-bit cycle on tx is the cycle after the fifo_rn edge.
REQ-023 Back-to-back: with FIFO non-empty and enable=1, IDLE lasts exactly 1 cycle between frames; frame period = (10+PARITY_EN)*CLKS_PER_BIT + 1 cycles.
REQ-024 enable deassert mid-frame: current frame completes unchanged; FSM then stays IDLE until enable=1.
REQ-025 fifo_empty or fifo_data changes during a frame have no effect on the frame in flight.
REQ-026 fifo_empty=1 in IDLE: fifo_rn=0, tx=1, busy=0 indefinitely.

Reset
REQ-027 reset=1 immediately (asynchronously) forces state=IDLE, tx=1, busy=0, frame_done=0, counters and shift register to 0; fifo_rn=0 while reset=1.
REQ-028 Reset mid-frame aborts the frame; the popped byte is discarded, not re-requested.
REQ-029 After reset release, first pop occurs on the first edge with enable=1 and fifo_empty=0.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=0, one byte 0xA5: one fifo_rn pulse; tx = 0,1,0,1,0,0,1,0,1,1 per bit, each held 4 cycles (40 cycles); frame_done at cycle 40.
REQ-031 CLKS_PER_BIT=4, PARITY_EN=1, byte 0x07: tx = 0,1,1,1,0,0,0,0,0,1(parity),1(stop); 44 cycles.
REQ-032 CLKS_PER_BIT=4, PARITY_EN=0, bytes 0x01,0x02 queued: fifo_rn pulses 41 cycles apart; exactly one idle cycle (tx=1) between frames.
REQ-033 fifo_empty=1 for 100 cycles, enable=1: fifo_rn never 1, tx=1, busy=0.
REQ-034 Reset asserted during DATA bit 3: tx=1 and busy=0 before the next clock edge; after release with FIFO empty, tx stays 1.
REQ-035 enable dropped during START with 2 bytes queued: first frame completes, no second pop until enable=1 again.
